// File: rtl/demux2_64_buf.sv
// Routes each accepted word to one of two channels, each with its own DEPTH-entry FIFO.
// Optional per-channel pop counters on xfer_cnt when DEMUX2_64_BUF_STATS_EN is defined.
module demux2_64_buf #(
  parameter  int SIZE  = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SIZE-1:0]      in_data,
  input  logic                 in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [1:0][SIZE-1:0] out_data,
  output logic [1:0]           out_valid,
  input  logic [1:0]           out_ready,
  output logic [1:0][CW-1:0]   out_count
`ifdef DEMUX2_64_BUF_STATS_EN
  ,
  output logic [1:0][15:0]     xfer_cnt
`endif
);

  logic [SIZE-1:0]      mem_q [2][DEPTH];
  logic [1:0][AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0][AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0][CW-1:0]   count_q, count_d;
  logic [1:0][SIZE-1:0] head_q, head_d;
  logic [1:0]           push, pop;

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    in_ready = (count_q[in_sel] != CW'(DEPTH));
    for (int k = 0; k < 2; k++) begin
      push[k]     = in_valid && in_ready && (in_sel == 1'(k));
      pop[k]      = (count_q[k] != '0) && out_ready[k];
      wr_ptr_d[k] = wr_ptr_q[k] + AW'(push[k]);
      rd_ptr_d[k] = rd_ptr_q[k] + AW'(pop[k]);
      count_d[k]  = count_q[k] + CW'(push[k]) - CW'(pop[k]);
      // Head is registered so it can hold its last value once the channel drains.
      head_d[k]   = head_q[k];
      if (count_d[k] != '0) begin
        if (push[k] && (wr_ptr_q[k] == rd_ptr_d[k])) begin
          head_d[k] = in_data;
        end else begin
          head_d[k] = mem_q[k][rd_ptr_d[k]];
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // NOTE: the storage array is not reset; count and the head register gate everything observable.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        mem_q[k][wr_ptr_q[k]] <= in_data;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      out_valid[k] = (count_q[k] != '0);
    end
  end

  assign out_data  = head_q;
  assign out_count = count_q;

`ifdef DEMUX2_64_BUF_STATS_EN
  logic [1:0][15:0] xfer_q, xfer_d;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      xfer_d[k] = xfer_q[k] + 16'(pop[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_q <= '0;
    end else begin
      xfer_q <= xfer_d;
    end
  end

  assign xfer_cnt = xfer_q;
`endif

endmodule
